// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// ALU op codes, opcodes, mux select codes and the immediate-format lookup.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRLINK = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_RESULT = 1'b1;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format depends only on the opcode; unknown opcodes fall back to I.
  function automatic logic [2:0] imm_src_for(input logic [6:0] opc);
    case (opc)
      OPC_STORE:  imm_src_for = IMM_S;
      OPC_BRANCH: imm_src_for = IMM_B;
      OPC_JAL:    imm_src_for = IMM_J;
      OPC_LUI:    imm_src_for = IMM_U;
      default:    imm_src_for = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from the latched instruction fields,
// plus a flag for instructions this core does not implement.
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_ctrl,
  output logic       unsupported
);

  // Map opcode/funct fields to an ALU op and flag anything outside the subset.
  always_comb begin
    alu_ctrl    = ALU_ADD;
    unsupported = 1'b0;
    case (opcode)
      OPC_RTYPE, OPC_ITYPE: begin
        case (funct3)
          // instr[30] on an I-type ADDI is immediate bit, not a SUB marker
          3'b000: alu_ctrl = (opcode == OPC_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctrl = ALU_SLL;
          3'b010: alu_ctrl = ALU_SLT;
          3'b011: unsupported = 1'b1;
          3'b100: alu_ctrl = ALU_XOR;
          3'b101: alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctrl = ALU_OR;
          3'b111: alu_ctrl = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_ctrl = ALU_SUB;
          3'b100, 3'b101: alu_ctrl = ALU_SLT;
          default:        unsupported = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI: alu_ctrl = ALU_ADD;
      default: unsupported = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and drives the datapath selects and enables.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       alu_lsb,
  input  logic       mem_ready,
  output logic [3:0] alu_ctrl,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal
);

  state_t     state;
  state_t     next_state;
  logic [3:0] dec_alu_ctrl;
  logic       dec_unsupported;
  logic       illegal_q;
  logic       branch_taken;

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_ctrl    (dec_alu_ctrl),
    .unsupported (dec_unsupported)
  );

  // State register; reset restarts at FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // Sticky illegal flag, set on entry to TRAP and cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   illegal_q <= 1'b0;
    else if (next_state == S_TRAP) illegal_q <= 1'b1;
  end

  // Branch condition from the ALU flags for the supported branch kinds.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = !zero;
      3'b100:  branch_taken = alu_lsb;
      3'b101:  branch_taken = !alu_lsb;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state and per-state datapath controls; reset forces everything idle.
  always_comb begin
    next_state = state;
    alu_ctrl   = ALU_ADD;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALUOUT;
    adr_src    = ADR_PC;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch/JAL target into ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (dec_unsupported) next_state = S_TRAP;
        else begin
          case (opcode)
            OPC_LOAD, OPC_STORE: next_state = S_MEMADR;
            OPC_RTYPE:           next_state = S_EXECR;
            OPC_ITYPE:           next_state = S_EXECI;
            OPC_BRANCH:          next_state = S_BRANCH;
            OPC_JAL:             next_state = S_JAL;
            OPC_JALR:            next_state = S_JALR;
            OPC_LUI:             next_state = S_LUI;
            default:             next_state = S_TRAP;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        next_state = (opcode == OPC_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = ADR_RESULT;
        result_src = RES_ALUOUT;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = ADR_RESULT;
        result_src = RES_ALUOUT;
        mem_write  = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_ctrl   = dec_alu_ctrl;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        alu_ctrl   = dec_alu_ctrl;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_ctrl   = dec_alu_ctrl;
        result_src = RES_ALUOUT;
        pc_write   = branch_taken;
        next_state = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target computed in DECODE; ALU forms the link
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        next_state = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        next_state = S_JALRLINK;
      end
      S_JALRLINK: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        next_state = S_ALUWB;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
    // Asynchronous abort: nothing is enabled while reset is held
    if (!rst_n) begin
      next_state = S_FETCH;
      alu_ctrl   = ALU_ADD;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RD2;
      result_src = RES_ALUOUT;
      adr_src    = ADR_PC;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
    end
  end

  assign imm_src = rst_n ? imm_src_for(opcode) : IMM_I;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle comparison of the full
// output bundle against hand-derived vectors for each instruction class.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       alu_lsb;
  logic       mem_ready;
  logic [3:0] alu_ctrl;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       illegal;
  logic [18:0] obs;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .alu_lsb    (alu_lsb),
    .mem_ready  (mem_ready),
    .alu_ctrl   (alu_ctrl),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {alu_ctrl, alu_src_a, alu_src_b, result_src, imm_src,
                adr_src, ir_write, pc_write, reg_write, mem_write, illegal};

  // Expected bundle: alu, a, b, result, imm, adr, ir, pc, reg, mem, illegal
  function automatic logic [18:0] ev(input logic [3:0] alu, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] rs,
                                     input logic [2:0] imm, input logic adr,
                                     input logic ir, input logic pc, input logic rw,
                                     input logic mw, input logic ill);
    return {alu, a, b, rs, imm, adr, ir, pc, rw, mw, ill};
  endfunction

  function automatic logic [18:0] fetch_v(input logic [2:0] imm, input logic rdy);
    return ev(4'h0, 2'b00, 2'b10, 2'b10, imm, 1'b0, rdy, rdy, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [18:0] decode_v(input logic [2:0] imm);
    return ev(4'h0, 2'b01, 2'b01, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [18:0] aluwb_v(input logic [2:0] imm);
    return ev(4'h0, 2'b00, 2'b00, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [18:0] idle;
    idle = 19'h0;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; alu_lsb = 1'b0;
    opcode = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0;
    #1;
    checks++;
    if (obs !== idle) begin
      errors++; $display("FAIL reset_async: got %05h expected %05h", obs, idle);
    end
    tick();
    checks++;
    if (obs !== idle) begin
      errors++; $display("FAIL reset_held: got %05h expected %05h", obs, idle);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [18:0] exp [4];
    opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
    exp[0] = fetch_v(3'b000, 1'b1);
    exp[1] = decode_v(3'b000);
    exp[2] = ev(4'h0, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp[3] = aluwb_v(3'b000);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (obs !== exp[c]) begin
        errors++; $display("FAIL add cycle%0d: got %05h expected %05h", c + 1, obs, exp[c]);
      end
      tick();
    end
  endtask

  task automatic test_funct();
    logic [6:0] opc [4] = '{7'b0110011, 7'b0010011, 7'b0010011, 7'b0110011};
    logic [2:0] f3  [4] = '{3'b000, 3'b000, 3'b101, 3'b010};
    logic       f7  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] alu [4] = '{4'b0001, 4'b0000, 4'b0111, 4'b0101};
    logic [1:0] bs  [4] = '{2'b00, 2'b01, 2'b01, 2'b00};
    logic [18:0] exp [4];
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      opcode = opc[i]; funct3 = f3[i]; funct7b5 = f7[i];
      exp[0] = fetch_v(3'b000, 1'b1);
      exp[1] = decode_v(3'b000);
      exp[2] = ev(alu[i], 2'b10, bs[i], 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp[3] = aluwb_v(3'b000);
      for (int c = 0; c < 4; c++) begin
        #1;
        checks++;
        if (obs !== exp[c]) begin
          errors++; $display("FAIL funct%0d cycle%0d: got %05h expected %05h", i, c + 1, obs, exp[c]);
        end
        tick();
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3  [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
    logic       zf  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       lsb [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] alu [4] = '{4'b0001, 4'b0001, 4'b0101, 4'b0101};
    logic       tk  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [18:0] exp [3];
    opcode = 7'b1100011; funct7b5 = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      funct3 = f3[i]; zero = zf[i]; alu_lsb = lsb[i];
      exp[0] = fetch_v(3'b010, 1'b1);
      exp[1] = decode_v(3'b010);
      exp[2] = ev(alu[i], 2'b10, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, tk[i], 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
        #1;
        checks++;
        if (obs !== exp[c]) begin
          errors++; $display("FAIL branch%0d cycle%0d: got %05h expected %05h", i, c + 1, obs, exp[c]);
        end
        tick();
      end
    end
    zero = 1'b0; alu_lsb = 1'b0;
  endtask

  task automatic test_load_stall();
    logic        rdy [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [18:0] exp [8];
    opcode = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    exp[0] = fetch_v(3'b000, 1'b0);
    exp[1] = fetch_v(3'b000, 1'b1);
    exp[2] = decode_v(3'b000);
    exp[3] = ev(4'h0, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp[4] = ev(4'h0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp[5] = exp[4];
    exp[6] = exp[4];
    exp[7] = ev(4'h0, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      mem_ready = rdy[c];
      #1;
      checks++;
      if (obs !== exp[c]) begin
        errors++; $display("FAIL load cycle%0d: got %05h expected %05h", c + 1, obs, exp[c]);
      end
      tick();
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [6:0]  opc [4] = '{7'b1101111, 7'b1100111, 7'b0110111, 7'b0100011};
    logic [18:0] exp [16];
    funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
    exp[0]  = fetch_v(3'b011, 1'b1);
    exp[1]  = decode_v(3'b011);
    exp[2]  = ev(4'h0, 2'b01, 2'b10, 2'b00, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp[3]  = aluwb_v(3'b011);
    exp[4]  = fetch_v(3'b000, 1'b1);
    exp[5]  = decode_v(3'b000);
    exp[6]  = ev(4'h0, 2'b10, 2'b01, 2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp[7]  = ev(4'h0, 2'b01, 2'b10, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp[8]  = fetch_v(3'b100, 1'b1);
    exp[9]  = decode_v(3'b100);
    exp[10] = ev(4'h0, 2'b11, 2'b01, 2'b00, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp[11] = aluwb_v(3'b100);
    exp[12] = fetch_v(3'b001, 1'b1);
    exp[13] = decode_v(3'b001);
    exp[14] = ev(4'h0, 2'b10, 2'b01, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp[15] = ev(4'h0, 2'b00, 2'b00, 2'b00, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 16; c++) begin
      opcode = opc[c / 4];
      #1;
      checks++;
      if (obs !== exp[c]) begin
        errors++; $display("FAIL b2b cycle%0d: got %05h expected %05h", c + 1, obs, exp[c]);
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [6:0]  opc [2] = '{7'b0110011, 7'b1111111};
    logic [2:0]  f3  [2] = '{3'b011, 3'b000};
    logic [18:0] exp [5];
    logic [18:0] trap_v;
    trap_v = ev(4'h0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mem_ready = 1'b1; funct7b5 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      opcode = opc[i]; funct3 = f3[i];
      exp[0] = fetch_v(3'b000, 1'b1);
      exp[1] = decode_v(3'b000);
      exp[2] = trap_v;
      exp[3] = trap_v;
      exp[4] = trap_v;
      for (int c = 0; c < 5; c++) begin
        #1;
        checks++;
        if (obs !== exp[c]) begin
          errors++; $display("FAIL illegal%0d cycle%0d: got %05h expected %05h", i, c + 1, obs, exp[c]);
        end
        tick();
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 19'h0) begin
        errors++; $display("FAIL illegal%0d reset_clear: got %05h expected %05h", i, obs, 19'h0);
      end
      tick();
      rst_n = 1'b1;
    end
  endtask

  task automatic test_reset_memwrite();
    logic [18:0] exp [5];
    logic [18:0] after;
    opcode = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
    exp[0] = fetch_v(3'b001, 1'b1);
    exp[1] = decode_v(3'b001);
    exp[2] = ev(4'h0, 2'b10, 2'b01, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp[3] = ev(4'h0, 2'b00, 2'b00, 2'b00, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    exp[4] = exp[3];
    for (int c = 0; c < 5; c++) begin
      if (c >= 3) mem_ready = 1'b0;
      #1;
      checks++;
      if (obs !== exp[c]) begin
        errors++; $display("FAIL swreset cycle%0d: got %05h expected %05h", c + 1, obs, exp[c]);
      end
      if (c < 4) tick();
    end
    // Still mid-MEMWRITE: pull reset between edges
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || obs !== 19'h0) begin
      errors++; $display("FAIL swreset abort: got %05h expected %05h", obs, 19'h0);
    end
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    after = fetch_v(3'b001, 1'b1);
    checks++;
    if (obs !== after) begin
      errors++; $display("FAIL swreset release: got %05h expected %05h", obs, after);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_funct();
    test_branch();
    test_load_stall();
    test_back_to_back();
    test_illegal();
    test_reset_memwrite();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
